// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding control beside the ID stage: operand forward selects, PC source,
// load-use stall and IF flush. Optional stall counter enabled by HAZ_STALL_CNT_EN.
module hazard_forward_unit #(
   parameter int REG_AW = 5,
   parameter int JSEL_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_rs_used,
   input  logic              id_rt_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_wreg,
   input  logic              id_m2r,
   input  logic [2:0]        id_jtype,
   input  logic              id_taken,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [JSEL_W-1:0] pc_sel,
   output logic              stall,
   output logic              flush
`ifdef HAZ_STALL_CNT_EN
   ,
   output logic [31:0]       stall_cnt
`endif
);

   logic [REG_AW-1:0] ex_rd, mem_rd;
   logic              ex_wreg, ex_m2r, mem_wreg, mem_m2r;
   logic [JSEL_W-1:0] pc_raw;
   logic              use_a, use_b;

   // A load in EX has no data yet, so an EX match on a load falls through to MEM.
   function automatic logic [1:0] fwd_sel(
      input logic [REG_AW-1:0] src,
      input logic              used,
      input logic [REG_AW-1:0] e_rd,
      input logic              e_wreg,
      input logic              e_m2r,
      input logic [REG_AW-1:0] m_rd,
      input logic              m_wreg
   );
      if (!used || src == '0)                       return 2'b00;
      else if (e_wreg && e_rd == src && !e_m2r)     return 2'b01;
      else if (m_wreg && m_rd == src)               return 2'b10;
      else                                          return 2'b00;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_rd    <= '0;
         ex_wreg  <= 1'b0;
         ex_m2r   <= 1'b0;
         mem_rd   <= '0;
         mem_wreg <= 1'b0;
         mem_m2r  <= 1'b0;
      end else begin
         mem_rd   <= ex_rd;
         mem_wreg <= ex_wreg;
         mem_m2r  <= ex_m2r;
         if (stall) begin
            ex_rd   <= '0;
            ex_wreg <= 1'b0;
            ex_m2r  <= 1'b0;
         end else begin
            ex_rd   <= id_rd;
            ex_wreg <= id_wreg;
            ex_m2r  <= id_m2r;
         end
      end
   end

   always_comb begin
      fwd_a = fwd_sel(id_rs, id_rs_used, ex_rd, ex_wreg, ex_m2r, mem_rd, mem_wreg);
      fwd_b = fwd_sel(id_rt, id_rt_used, ex_rd, ex_wreg, ex_m2r, mem_rd, mem_wreg);
   end

   always_comb begin
      use_a = id_rs_used && (id_rs == ex_rd);
      use_b = id_rt_used && (id_rt == ex_rd);
      stall = ex_wreg && ex_m2r && (ex_rd != '0) && (use_a || use_b);
   end

   always_comb begin
      pc_raw = '0;
      case (id_jtype)
         3'b001:         pc_raw = id_taken ? JSEL_W'(3'b001) : '0;
         3'b010, 3'b011: pc_raw = JSEL_W'(3'b010);
         3'b100, 3'b101: pc_raw = JSEL_W'(3'b100);
         default:        pc_raw = '0;
      endcase
      // A stalled ID instruction is replayed next cycle, so its transfer is deferred.
      pc_sel = stall ? '0 : pc_raw;
      flush  = (pc_sel != '0);
   end

`ifdef HAZ_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     stall_cnt <= '0;
      else if (stall) stall_cnt <= stall_cnt + 32'd1;
   end
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: in-flight instruction model checked every cycle,
// plus hand-computed literal expectations at each scenario.
module tb_hazard_forward_unit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [4:0] id_rs, id_rt, id_rd;
   logic       id_rs_used, id_rt_used, id_wreg, id_m2r, id_taken;
   logic [2:0] id_jtype;
   logic [1:0] fwd_a, fwd_b;
   logic [2:0] pc_sel;
   logic       stall, flush;
`ifdef HAZ_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   hazard_forward_unit #(.REG_AW(5), .JSEL_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
      .id_rd(id_rd), .id_wreg(id_wreg), .id_m2r(id_m2r),
      .id_jtype(id_jtype), .id_taken(id_taken),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_sel(pc_sel), .stall(stall), .flush(flush)
`ifdef HAZ_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   // Model: pipe[0] is the instruction in EX, pipe[1] the one in MEM.
   typedef struct packed {
      logic [4:0] rd;
      logic       w;
      logic       m;
   } ins_t;
   ins_t        pipe [2];
   int unsigned m_cnt;

   function automatic logic [1:0] m_fwd(input logic [4:0] r, input logic used);
      logic [1:0] sel;
      sel = 2'b00;
      if (used && r != 5'd0)
         for (int s = 1; s >= 0; s--)
            if (pipe[s].w && pipe[s].rd == r && !(s == 0 && pipe[s].m)) sel = 2'(s + 1);
      return sel;
   endfunction

   function automatic logic m_stall();
      return pipe[0].w && pipe[0].m && pipe[0].rd != 5'd0 &&
             ((id_rs_used && id_rs == pipe[0].rd) || (id_rt_used && id_rt == pipe[0].rd));
   endfunction

   function automatic logic [2:0] m_pc();
      if (m_stall()) return 3'b000;
      case (id_jtype[2:1])
         2'b00:   return (id_jtype[0] && id_taken) ? 3'b001 : 3'b000;
         2'b01:   return 3'b010;
         2'b10:   return 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe[0] <= '0;
         pipe[1] <= '0;
         m_cnt   <= 0;
      end else begin
         pipe[1] <= pipe[0];
         pipe[0] <= m_stall() ? ins_t'(0) : ins_t'({id_rd, id_wreg, id_m2r});
         if (m_stall()) m_cnt <= m_cnt + 1;
      end
   end

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         cmp("model_fwd_a", 32'(fwd_a), 32'(m_fwd(id_rs, id_rs_used)));
         cmp("model_fwd_b", 32'(fwd_b), 32'(m_fwd(id_rt, id_rt_used)));
         cmp("model_stall", 32'(stall), 32'(m_stall()));
         cmp("model_pc_sel", 32'(pc_sel), 32'(m_pc()));
         cmp("model_flush", 32'(flush), 32'(m_pc() != 3'b000));
`ifdef HAZ_STALL_CNT_EN
         cmp("model_stall_cnt", stall_cnt, m_cnt);
`endif
      end
   end

   task automatic drive(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                        input logic rtu, input logic [4:0] rd, input logic w, input logic m,
                        input logic [2:0] jt, input logic tk);
      id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
      id_rd = rd; id_wreg = w; id_m2r = m; id_jtype = jt; id_taken = tk;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic lit(input string name, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [2:0] pc, input logic st, input logic fl);
      cmp({name, "_fwd_a"}, 32'(fwd_a), 32'(fa));
      cmp({name, "_fwd_b"}, 32'(fwd_b), 32'(fb));
      cmp({name, "_pc_sel"}, 32'(pc_sel), 32'(pc));
      cmp({name, "_stall"}, 32'(stall), 32'(st));
      cmp({name, "_flush"}, 32'(flush), 32'(fl));
   endtask

   initial begin
      drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 0);
      #2;
      lit("reset", 2'b00, 2'b00, 3'b000, 0, 0);
      #5 rst_n = 1'b1;

      // EX forwarding, then r0 destination never forwards
      drive(0, 0, 0, 0, 5'd3, 1, 0, 3'b000, 0); step();
      drive(5'd3, 1, 0, 0, 5'd0, 1, 0, 3'b000, 0); #1;
      lit("ex_fwd", 2'b01, 2'b00, 3'b000, 0, 0);
      step();
      drive(5'd0, 1, 0, 0, 0, 0, 0, 3'b000, 0); #1;
      lit("r0_dest", 2'b00, 2'b00, 3'b000, 0, 0);
      step();

      // EX over MEM priority, then MEM only
      drive(0, 0, 0, 0, 5'd5, 1, 0, 3'b000, 0); step();
      drive(0, 0, 0, 0, 5'd5, 1, 0, 3'b000, 0); step();
      drive(0, 0, 5'd5, 1, 0, 0, 0, 3'b000, 0); #1;
      lit("prio_ex", 2'b00, 2'b01, 3'b000, 0, 0);
      step();
      drive(0, 0, 0, 0, 5'd5, 1, 0, 3'b000, 0); step();
      drive(0, 0, 0, 0, 5'd6, 1, 0, 3'b000, 0); step();
      drive(0, 0, 5'd5, 1, 0, 0, 0, 3'b000, 0); #1;
      lit("prio_mem", 2'b00, 2'b10, 3'b000, 0, 0);
      step();

      // Load-use: one stall cycle, then MEM forward
      drive(0, 0, 0, 0, 5'd4, 1, 1, 3'b000, 0); step();
      drive(5'd4, 1, 0, 0, 0, 0, 0, 3'b000, 0); #1;
      lit("lu_stall", 2'b00, 2'b00, 3'b000, 1, 0);
      step();
      lit("lu_after", 2'b10, 2'b00, 3'b000, 0, 0);
      step();

      // Control transfers
      drive(0, 0, 0, 0, 0, 0, 0, 3'b001, 1); #1; lit("br_taken", 2'b00, 2'b00, 3'b001, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 3'b001, 0); #1; lit("br_not", 2'b00, 2'b00, 3'b000, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 3'b010, 0); #1; lit("jump", 2'b00, 2'b00, 3'b010, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 3'b011, 0); #1; lit("jal", 2'b00, 2'b00, 3'b010, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 3'b100, 0); #1; lit("jr", 2'b00, 2'b00, 3'b100, 0, 1);
      drive(0, 0, 0, 0, 0, 0, 0, 3'b110, 1); #1; lit("illegal", 2'b00, 2'b00, 3'b000, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 3'b000, 1); #1; lit("seq", 2'b00, 2'b00, 3'b000, 0, 0);
      step();

      // jr during load-use stall is deferred one cycle
      drive(0, 0, 0, 0, 5'd7, 1, 1, 3'b000, 0); step();
      drive(5'd7, 1, 0, 0, 0, 0, 0, 3'b100, 0); #1;
      lit("jr_stall", 2'b00, 2'b00, 3'b000, 1, 0);
      step();
      lit("jr_after", 2'b10, 2'b00, 3'b100, 0, 1);
      step();

      // Asynchronous reset mid-stream with ex_wreg=1
      drive(0, 0, 0, 0, 5'd9, 1, 0, 3'b000, 0); step();
      drive(5'd9, 1, 5'd9, 1, 0, 0, 0, 3'b000, 0); #1;
      lit("pre_rst", 2'b01, 2'b01, 3'b000, 0, 0);
      rst_n = 1'b0; #1;
      lit("async_rst", 2'b00, 2'b00, 3'b000, 0, 0);
      #1 rst_n = 1'b1;
      step();
      lit("post_rst", 2'b00, 2'b00, 3'b000, 0, 0);

      // Three load-use events after reset
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 0, 5'd12, 1, 1, 3'b000, 0); step();
         drive(0, 0, 5'd12, 1, 0, 0, 0, 3'b000, 0); #1;
         lit("lu3_stall", 2'b00, 2'b00, 3'b000, 1, 0);
         step();
         lit("lu3_after", 2'b00, 2'b10, 3'b000, 0, 0);
         step();
      end
`ifdef HAZ_STALL_CNT_EN
      cmp("stall_cnt_3", stall_cnt, 32'd3);
`endif
      cmp("model_cnt_3", m_cnt, 32'd3);

      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
